iq_rx_fifo: RTL and testbench

IQ_RX_FIFO -- requirements
Module: iq_rx_fifo

---
 rtl/iq_rx_fifo.sv | 83 ++++++++
 tb/tb_iq_rx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/iq_rx_fifo.sv
// rtl/iq_rx_fifo.sv - I/Q receive word FIFO with registered read port and overflow statistics
module iq_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic [31:0]           i_push_data,
  input  logic                  i_pull,
  output logic [31:0]           o_pulled_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [7:0]            o_overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_AF   = (DEPTH_LOG2 + 1)'(DEPTH - AF_MARGIN);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [7:0]            ovf_cnt;
  logic [31:0]           pulled_data;
  logic                  pull_ok;
  logic                  push_ok;

  // A pull on an empty FIFO never falls through to a same-cycle push.
  assign pull_ok = i_pull && (level != '0);
  assign push_ok = i_push && ((level != LVL_FULL) || pull_ok);

  // Storage is not reset; the level counter keeps unwritten entries unreachable.
  always_ff @(posedge i_sys_clk) begin
    if (push_ok && !i_flush) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      ovf_cnt     <= '0;
      pulled_data <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // mem read sees the pre-write word when full push and pull collide.
      if (pull_ok) begin
        rd_ptr      <= rd_ptr + 1'b1;
        pulled_data <= mem[rd_ptr];
      end
      if (push_ok && !pull_ok) begin
        level <= level + 1'b1;
      end else if (pull_ok && !push_ok) begin
        level <= level - 1'b1;
      end
      if (i_push && !push_ok && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

  assign o_pulled_data  = pulled_data;
  assign o_level        = level;
  assign o_overflow_cnt = ovf_cnt;
  assign o_full         = (level == LVL_FULL);
  assign o_empty        = (level == '0);
  assign o_almost_full  = (level >= LVL_AF);

endmodule

// File: tb/tb_iq_rx_fifo.sv
// tb/tb_iq_rx_fifo.sv - directed vector bench for iq_rx_fifo
module tb_iq_rx_fifo;

  logic        clk;
  logic        i_reset;
  logic        i_flush;
  logic        i_push;
  logic [31:0] i_push_data;
  logic        i_pull;
  logic [31:0] o_pulled_data;
  logic        o_full;
  logic        o_empty;
  logic        o_almost_full;
  logic [4:0]  o_level;
  logic [7:0]  o_overflow_cnt;

  int total;
  int passed;

  iq_rx_fifo #(.DEPTH_LOG2(4), .AF_MARGIN(2)) dut (
    .i_sys_clk     (clk),
    .i_reset       (i_reset),
    .i_flush       (i_flush),
    .i_push        (i_push),
    .i_push_data   (i_push_data),
    .i_pull        (i_pull),
    .o_pulled_data (o_pulled_data),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_almost_full (o_almost_full),
    .o_level       (o_level),
    .o_overflow_cnt(o_overflow_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        push;
    logic [31:0] d;
    logic        pull;
    logic        flush;
    logic [4:0]  lvl;
    logic [31:0] q;
    logic        empty;
    logic        full;
    logic        af;
    logic [7:0]  ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic push, input logic [31:0] d, input logic pull, input logic flush);
    i_push = push;
    i_push_data = d;
    i_pull = pull;
    i_flush = flush;
    @(posedge clk);
    #1;
    i_push = 1'b0;
    i_pull = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " level"}, 32'(o_level), 32'd0);
    check({tag, " data"}, o_pulled_data, 32'h0);
    check({tag, " empty"}, 32'(o_empty), 32'd1);
    check({tag, " full"}, 32'(o_full), 32'd0);
    check({tag, " af"}, 32'(o_almost_full), 32'd0);
    check({tag, " ovf"}, 32'(o_overflow_cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_d;
    total = 0;
    passed = 0;
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_push = 1'b0;
    i_pull = 1'b0;
    i_push_data = '0;

    // push, data, pull, flush | level, pulled, empty, full, af, ovf
    vecs[0]  = '{1'b1, 32'hA0000001, 1'b0, 1'b0, 5'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 32'hA0000002, 1'b0, 1'b0, 5'd2, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 32'hA0000003, 1'b0, 1'b0, 5'd3, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd2, 32'hA0000001, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd1, 32'hA0000002, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 32'hA0000003, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 32'hA0000003, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 5'd1, 32'hA0000003, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 32'h55555555, 1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b0, 1'b0, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].push, vecs[i].d, vecs[i].pull, vecs[i].flush);
      check($sformatf("vec%0d level", i), 32'(o_level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d data", i), o_pulled_data, vecs[i].q);
      check($sformatf("vec%0d empty", i), 32'(o_empty), 32'(vecs[i].empty));
      check($sformatf("vec%0d full", i), 32'(o_full), 32'(vecs[i].full));
      check($sformatf("vec%0d af", i), 32'(o_almost_full), 32'(vecs[i].af));
      check($sformatf("vec%0d ovf", i), 32'(o_overflow_cnt), 32'(vecs[i].ovf));
    end

    // Fill to capacity, watching almost-full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'hB0000000 + 32'(i), 1'b0, 1'b0);
      check($sformatf("fill%0d level", i), 32'(o_level), 32'(i + 1));
      check($sformatf("fill%0d af", i), 32'(o_almost_full), 32'((i + 1) >= 14));
      check($sformatf("fill%0d full", i), 32'(o_full), 32'((i + 1) == 16));
    end
    step(1'b1, 32'hBBBBBBBB, 1'b0, 1'b0);
    check("drop17 level", 32'(o_level), 32'd16);
    check("drop17 ovf", 32'(o_overflow_cnt), 32'd1);

    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    check("fullpp level", 32'(o_level), 32'd16);
    check("fullpp data", o_pulled_data, 32'hB0000000);
    check("fullpp ovf", 32'(o_overflow_cnt), 32'd1);
    check("fullpp full", 32'(o_full), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      exp_d = (i == 16) ? 32'hDEADBEEF : 32'hB0000000 + 32'(i);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      check($sformatf("drain%0d data", i), o_pulled_data, exp_d);
      check($sformatf("drain%0d level", i), 32'(o_level), 32'(16 - i));
    end
    check("drain empty", 32'(o_empty), 32'd1);

    // Saturating overflow then flush with a push pending.
    for (int i = 0; i < 16; i++) step(1'b1, 32'hC1000000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) step(1'b1, 32'hEEEEEEEE, 1'b0, 1'b0);
    check("ovf255", 32'(o_overflow_cnt), 32'd255);
    for (int i = 0; i < 45; i++) step(1'b1, 32'hEEEEEEEE, 1'b0, 1'b0);
    check("ovf sat", 32'(o_overflow_cnt), 32'd255);
    check("ovf level", 32'(o_level), 32'd16);
    step(1'b1, 32'hFFFF0000, 1'b0, 1'b1);
    check("flush level", 32'(o_level), 32'd0);
    check("flush ovf", 32'(o_overflow_cnt), 32'd0);
    check("flush empty", 32'(o_empty), 32'd1);
    check("flush data", o_pulled_data, 32'hDEADBEEF);

    // 40 words streamed with pulls, pointers wrap twice.
    for (int i = 0; i < 40; i++) begin
      logic do_pull;
      do_pull = (i >= 3);
      if (do_pull && q.size() > 0) exp_d = q.pop_front();
      q.push_back(32'hC0000000 + 32'(i));
      step(1'b1, 32'hC0000000 + 32'(i), do_pull, 1'b0);
      check($sformatf("wrap%0d level", i), 32'(o_level), 32'(q.size()));
      if (do_pull) check($sformatf("wrap%0d data", i), o_pulled_data, exp_d);
    end

    // Asynchronous reset mid-cycle with words still stored.
    #2;
    i_reset = 1'b0;
    #1;
    check_reset_vals("async rst");
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hE0000001, 1'b0, 1'b0);
    step(1'b1, 32'hE0000002, 1'b0, 1'b0);
    check("post rst level", 32'(o_level), 32'd2);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("post rst first", o_pulled_data, 32'hE0000001);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("post rst second", o_pulled_data, 32'hE0000002);
    check("post rst empty", 32'(o_empty), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
